// File: rtl/alu_param_pkg.sv
// Shared types and command decode helpers for the parametrised ALU core.
// Command encodings are 4 bits wide regardless of the CMD field width at the top.
package alu_param_pkg;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A, A_INC_B, A_DEC_B,
    A_CMP, A_MUL_INC, A_MUL_SHL
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_A, L_NOT_B,
    L_SHR1_A, L_SHL1_A, L_SHR1_B, L_SHL1_B, L_ROL, L_ROR
  } logic_cmd_e;

  typedef enum logic [1:0] {IDLE, WAIT_OP, MUL} state_e;

  typedef enum logic [1:0] {SEL_ALU, SEL_MUL, SEL_TMO} res_sel_e;

  localparam logic [1:0] NEED_A  = 2'b01;
  localparam logic [1:0] NEED_B  = 2'b10;
  localparam logic [1:0] NEED_AB = 2'b11;

  function automatic logic cmd_known(input logic mode, input logic [3:0] cmd);
    return mode ? (cmd <= 4'd10) : (cmd <= 4'd13);
  endfunction

  function automatic logic cmd_is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == A_MUL_INC) || (cmd == A_MUL_SHL));
  endfunction

  function automatic logic [1:0] op_mask(input logic mode, input logic [3:0] cmd);
    logic [1:0] m;
    m = NEED_AB;
    if (mode) begin
      case (arith_cmd_e'(cmd))
        A_INC_A, A_DEC_A: m = NEED_A;
        A_INC_B, A_DEC_B: m = NEED_B;
        default:          m = NEED_AB;
      endcase
    end else begin
      case (logic_cmd_e'(cmd))
        L_NOT_A, L_SHR1_A, L_SHL1_A: m = NEED_A;
        L_NOT_B, L_SHR1_B, L_SHL1_B: m = NEED_B;
        default:                     m = NEED_AB;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Multiplier with MUL_LAT registered stages; the first stage registers the product.
// Valid travels alongside the data and the whole pipe stalls when ce is low.
module alu_mul_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [WIDTH:0]       a,
  input  logic [WIDTH:0]       b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [2*WIDTH-1:0] prod_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;

  // Operands widened first so the product is taken modulo 2^(2*WIDTH), not WIDTH+1.
  assign ax   = {{(WIDTH-1){1'b0}}, a};
  assign bx   = {{(WIDTH-1){1'b0}}, b};
  assign prod = ax * bx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else if (ce) begin
      prod_q[0] <= prod;
      vld_q[0]  <= in_valid;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[MUL_LAT-1];
  assign product   = prod_q[MUL_LAT-1];

endmodule

// File: rtl/alu_param_core.sv
// Width-generic ALU with operand wait window, pipelined multiply and RES_VALID/BUSY handshake.
// Results and flags are registered and held until the next RES_VALID pulse.
module alu_param_core
  import alu_param_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CMD_W       = 4,
  parameter int unsigned WAIT_CYCLES = 16,
  parameter int unsigned MUL_LAT     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic [CMD_W-1:0]     CMD,
  input  logic [1:0]           INP_VALID,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic                 CIN,
  output logic [2*WIDTH-1:0]   RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 L,
  output logic                 E,
  output logic                 ERR,
  output logic                 RES_VALID,
  output logic                 BUSY
);

  localparam int unsigned RW    = 2 * WIDTH;
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [WIDTH:0]   ONE1 = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONEW = WIDTH'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lat_mode, lat_cin;
  logic [3:0]         lat_cmd;
  logic [WIDTH-1:0]   lat_a, lat_b;
  logic [1:0]         lat_iv;
  logic [RW-1:0]      res_q;
  logic               cout_q, oflow_q, g_q, l_q, e_q, err_q, rv_q;

  logic [CMD_W+3:0]   cmd_ext;
  logic [3:0]         cmd4;
  logic               cmd_hi_nz, in_wait;
  logic               e_mode, e_cin, e_valid, ready;
  logic [3:0]         e_cmd;
  logic [WIDTH-1:0]   e_a, e_b;
  logic [WIDTH:0]     a1, b1, cin1;
  logic [1:0]         have, mask;
  logic [SH_W-1:0]    amt;
  logic               amt_hi_nz;
  logic [RW-1:0]      rol_full, ror_full;

  logic               fire, mul_start, latch;
  res_sel_e           fire_sel;
  logic [WIDTH:0]     r1, mul_a, mul_b;
  logic [RW-1:0]      alu_res, mul_prod;
  logic               alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err, mul_vld;

  // Wider CMD fields are accepted; any set bit above the 4-bit code makes the command invalid.
  assign cmd_ext   = {4'b0000, CMD};
  assign cmd4      = cmd_ext[3:0];
  assign cmd_hi_nz = |(cmd_ext >> 4);

  // While waiting, the latched operation is completed using whichever operand was missing.
  assign in_wait = (state_q == WAIT_OP);
  assign e_mode  = in_wait ? lat_mode : MODE;
  assign e_cmd   = in_wait ? lat_cmd  : cmd4;
  assign e_cin   = in_wait ? lat_cin  : CIN;
  assign e_a     = (in_wait && lat_iv[0]) ? lat_a : OPA;
  assign e_b     = (in_wait && lat_iv[1]) ? lat_b : OPB;
  assign e_valid = in_wait ? 1'b1 : (cmd_known(MODE, cmd4) && !cmd_hi_nz);
  assign have    = in_wait ? (lat_iv | INP_VALID) : INP_VALID;
  assign mask    = op_mask(e_mode, e_cmd);
  assign ready   = ((have & mask) == mask);

  assign a1        = {1'b0, e_a};
  assign b1        = {1'b0, e_b};
  assign cin1      = {{WIDTH{1'b0}}, e_cin};
  assign amt       = e_b[SH_W-1:0];
  assign amt_hi_nz = |(e_b >> SH_W);
  assign rol_full  = {e_a, e_a} << amt;
  assign ror_full  = {e_a, e_a} >> amt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_mode <= 1'b0;
      lat_cmd  <= '0;
      lat_cin  <= 1'b0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_iv   <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      oflow_q  <= 1'b0;
      g_q      <= 1'b0;
      l_q      <= 1'b0;
      e_q      <= 1'b0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= fire;
      if (latch) begin
        lat_mode <= MODE;
        lat_cmd  <= cmd4;
        lat_cin  <= CIN;
        lat_a    <= OPA;
        lat_b    <= OPB;
        lat_iv   <= INP_VALID;
      end
      if (fire) begin
        case (fire_sel)
          SEL_ALU: begin
            res_q <= alu_res;   cout_q <= alu_cout; oflow_q <= alu_oflow;
            g_q   <= alu_g;     l_q    <= alu_l;    e_q     <= alu_e;
            err_q <= alu_err;
          end
          SEL_MUL: begin
            res_q <= mul_prod;  cout_q <= 1'b0; oflow_q <= 1'b0;
            g_q   <= 1'b0;      l_q    <= 1'b0; e_q     <= 1'b0;
            err_q <= 1'b0;
          end
          default: begin
            res_q <= '0;        cout_q <= 1'b0; oflow_q <= 1'b0;
            g_q   <= 1'b0;      l_q    <= 1'b0; e_q     <= 1'b0;
            err_q <= 1'b1;
          end
        endcase
      end
    end else begin
      rv_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fire      = 1'b0;
    fire_sel  = SEL_ALU;
    mul_start = 1'b0;
    latch     = 1'b0;
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (INP_VALID != 2'b00) begin
            if (!e_valid) begin
              fire = 1'b1;
            end else if (ready) begin
              if (cmd_is_mul(e_mode, e_cmd)) begin
                mul_start = 1'b1;
                state_d   = MUL;
              end else begin
                fire = 1'b1;
              end
            end else begin
              latch   = 1'b1;
              cnt_d   = '0;
              state_d = WAIT_OP;
            end
          end
        end
        WAIT_OP: begin
          if (ready) begin
            cnt_d = '0;
            if (cmd_is_mul(e_mode, e_cmd)) begin
              mul_start = 1'b1;
              state_d   = MUL;
            end else begin
              fire    = 1'b1;
              state_d = IDLE;
            end
          end else if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            fire     = 1'b1;
            fire_sel = SEL_TMO;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MUL: begin
          if (mul_vld) begin
            fire     = 1'b1;
            fire_sel = SEL_MUL;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    r1        = '0;
    alu_cout  = 1'b0;
    alu_oflow = 1'b0;
    alu_g     = 1'b0;
    alu_l     = 1'b0;
    alu_e     = 1'b0;
    alu_err   = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    if (!e_valid) begin
      alu_err = 1'b1;
    end else if (e_mode) begin
      case (arith_cmd_e'(e_cmd))
        A_ADD:     begin r1 = a1 + b1;        alu_cout = r1[WIDTH]; end
        A_SUB:     begin r1 = {1'b0, e_a - e_b}; alu_oflow = (e_a < e_b); end
        A_ADD_CIN: begin r1 = a1 + b1 + cin1; alu_cout = r1[WIDTH]; end
        A_SUB_CIN: begin r1 = {1'b0, e_a - e_b - WIDTH'(e_cin)}; alu_oflow = (a1 < (b1 + cin1)); end
        A_INC_A:   begin r1 = a1 + ONE1;      alu_cout = r1[WIDTH]; end
        A_DEC_A:   begin r1 = {1'b0, e_a - ONEW}; alu_oflow = (e_a == '0); end
        A_INC_B:   begin r1 = b1 + ONE1;      alu_cout = r1[WIDTH]; end
        A_DEC_B:   begin r1 = {1'b0, e_b - ONEW}; alu_oflow = (e_b == '0); end
        A_CMP:     begin alu_g = (e_a > e_b); alu_l = (e_a < e_b); alu_e = (e_a == e_b); end
        A_MUL_INC: begin mul_a = a1 + ONE1; mul_b = b1 + ONE1; end
        A_MUL_SHL: begin mul_a = {1'b0, e_a << 1}; mul_b = b1; end
        default:   alu_err = 1'b1;
      endcase
    end else begin
      case (logic_cmd_e'(e_cmd))
        L_AND:    r1 = {1'b0, e_a & e_b};
        L_NAND:   r1 = {1'b0, ~(e_a & e_b)};
        L_OR:     r1 = {1'b0, e_a | e_b};
        L_NOR:    r1 = {1'b0, ~(e_a | e_b)};
        L_XOR:    r1 = {1'b0, e_a ^ e_b};
        L_XNOR:   r1 = {1'b0, ~(e_a ^ e_b)};
        L_NOT_A:  r1 = {1'b0, ~e_a};
        L_NOT_B:  r1 = {1'b0, ~e_b};
        L_SHR1_A: r1 = {1'b0, e_a >> 1};
        L_SHL1_A: r1 = {1'b0, e_a << 1};
        L_SHR1_B: r1 = {1'b0, e_b >> 1};
        L_SHL1_B: r1 = {1'b0, e_b << 1};
        L_ROL:    if (amt_hi_nz) alu_err = 1'b1; else r1 = {1'b0, rol_full[RW-1:WIDTH]};
        L_ROR:    if (amt_hi_nz) alu_err = 1'b1; else r1 = {1'b0, ror_full[WIDTH-1:0]};
        default:  alu_err = 1'b1;
      endcase
    end
    alu_res = {{(WIDTH-1){1'b0}}, r1};
  end

  alu_mul_pipe #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (CLK),
    .rst_n     (RST),
    .ce        (CE),
    .in_valid  (mul_start),
    .a         (mul_a),
    .b         (mul_b),
    .out_valid (mul_vld),
    .product   (mul_prod)
  );

  assign RES       = res_q;
  assign COUT      = cout_q;
  assign OFLOW     = oflow_q;
  assign G         = g_q;
  assign L         = l_q;
  assign E         = e_q;
  assign ERR       = err_q;
  assign RES_VALID = rv_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_param_core.sv
// Directed self-checking bench for alu_param_core at WIDTH=8, WAIT_CYCLES=16, MUL_LAT=2.
module tb_alu_param_core;

  logic        CLK = 1'b0;
  logic        RST, CE, MODE, CIN;
  logic [3:0]  CMD;
  logic [1:0]  INP_VALID;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, L, E, ERR, RES_VALID, BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        m;
    logic [3:0]  c;
    logic [1:0]  iv;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [15:0] res;
    logic [5:0]  fl;   // {COUT, OFLOW, G, L, E, ERR}
  } vec_t;

  always #5 CLK = ~CLK;

  alu_param_core #(
    .WIDTH       (8),
    .CMD_W       (4),
    .WAIT_CYCLES (16),
    .MUL_LAT     (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .MODE      (MODE),
    .CMD       (CMD),
    .INP_VALID (INP_VALID),
    .OPA       (OPA),
    .OPB       (OPB),
    .CIN       (CIN),
    .RES       (RES),
    .COUT      (COUT),
    .OFLOW     (OFLOW),
    .G         (G),
    .L         (L),
    .E         (E),
    .ERR       (ERR),
    .RES_VALID (RES_VALID),
    .BUSY      (BUSY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                       input logic [7:0] a, input logic [7:0] b, input logic ci);
    MODE = m; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
  endtask

  task automatic test_reset();
    RST = 1'b0; CE = 1'b1;
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    #2;
    checks++;
    if ({RES, COUT, OFLOW, G, L, E, ERR, RES_VALID, BUSY} !== 24'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {RES, COUT, OFLOW, G, L, E, ERR, RES_VALID, BUSY});
    end
    tick(); tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({RES_VALID, BUSY} !== 2'b00) begin
      errors++; $display("FAIL reset_release got %b exp 00", {RES_VALID, BUSY});
    end
  endtask

  task automatic test_add();
    drive(1'b1, 4'd0, 2'b11, 8'd200, 8'd100, 1'b0);
    tick();
    checks++;
    if (RES !== 16'h012C) begin errors++; $display("FAIL add_res got %h exp 012c", RES); end
    checks++;
    if ({COUT, OFLOW, ERR, RES_VALID, BUSY} !== 5'b10010) begin
      errors++; $display("FAIL add_flags got %b exp 10010", {COUT, OFLOW, ERR, RES_VALID, BUSY});
    end
    INP_VALID = 2'b00;
    tick();
    checks++;
    if ({RES_VALID, RES} !== {1'b0, 16'h012C}) begin
      errors++; $display("FAIL add_hold got rv=%b res=%h exp rv=0 res=012c", RES_VALID, RES);
    end
  endtask

  task automatic test_sub_cmp();
    drive(1'b1, 4'd1, 2'b11, 8'd5, 8'd7, 1'b0);
    tick();
    checks++;
    if ({RES, COUT, OFLOW, RES_VALID} !== {16'h00FE, 3'b011}) begin
      errors++; $display("FAIL sub got res=%h c=%b o=%b rv=%b exp res=00fe c=0 o=1 rv=1", RES, COUT, OFLOW, RES_VALID);
    end
    drive(1'b1, 4'd8, 2'b11, 8'd9, 8'd9, 1'b0);
    tick();
    checks++;
    if ({RES, G, L, E, OFLOW, RES_VALID} !== {16'h0000, 5'b00101}) begin
      errors++; $display("FAIL cmp_eq got res=%h gle=%b%b%b o=%b rv=%b exp res=0 gle=001 o=0 rv=1",
                         RES, G, L, E, OFLOW, RES_VALID);
    end
    INP_VALID = 2'b00;
    tick();
  endtask

  task automatic test_mul();
    drive(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
    tick();
    checks++;
    if ({BUSY, RES_VALID} !== 2'b10) begin errors++; $display("FAIL mul_e1 got busy,rv=%b exp 10", {BUSY, RES_VALID}); end
    drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd1, 1'b0);
    tick();
    checks++;
    if ({BUSY, RES_VALID} !== 2'b10) begin errors++; $display("FAIL mul_e2 got busy,rv=%b exp 10", {BUSY, RES_VALID}); end
    tick();
    checks++;
    if ({RES, RES_VALID, BUSY} !== {16'd20, 2'b10}) begin
      errors++; $display("FAIL mul_inc got res=%0d rv=%b busy=%b exp res=20 rv=1 busy=0", RES, RES_VALID, BUSY);
    end
    INP_VALID = 2'b00;
    tick();
    checks++;
    if ({RES, RES_VALID} !== {16'd20, 1'b0}) begin
      errors++; $display("FAIL mul_after got res=%0d rv=%b exp res=20 rv=0", RES, RES_VALID);
    end
    drive(1'b1, 4'd10, 2'b11, 8'h90, 8'd3, 1'b0);
    tick();
    INP_VALID = 2'b00;
    tick(); tick();
    checks++;
    if ({RES, RES_VALID} !== {16'd96, 1'b1}) begin
      errors++; $display("FAIL mul_shl got res=%0d rv=%b exp res=96 rv=1", RES, RES_VALID);
    end
  endtask

  task automatic test_rotate_wait();
    drive(1'b0, 4'd12, 2'b01, 8'h81, 8'h00, 1'b0);
    tick();
    checks++;
    if ({BUSY, RES_VALID} !== 2'b10) begin errors++; $display("FAIL rolw_wait got busy,rv=%b exp 10", {BUSY, RES_VALID}); end
    drive(1'b0, 4'd0, 2'b00, 8'hFF, 8'hFF, 1'b0);
    repeat (4) tick();
    drive(1'b0, 4'd0, 2'b10, 8'hFF, 8'h01, 1'b0);
    tick();
    checks++;
    if ({RES, ERR, RES_VALID, BUSY} !== {16'h0003, 3'b010}) begin
      errors++; $display("FAIL rolw_res got res=%h err=%b rv=%b busy=%b exp res=0003 err=0 rv=1 busy=0",
                         RES, ERR, RES_VALID, BUSY);
    end
    INP_VALID = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    drive(1'b1, 4'd0, 2'b01, 8'd1, 8'd0, 1'b0);
    tick();
    INP_VALID = 2'b00;
    repeat (15) tick();
    checks++;
    if ({RES_VALID, BUSY} !== 2'b01) begin errors++; $display("FAIL tmo_early got rv,busy=%b exp 01", {RES_VALID, BUSY}); end
    tick();
    checks++;
    if ({RES, ERR, RES_VALID, BUSY} !== {16'h0000, 3'b110}) begin
      errors++; $display("FAIL tmo_fire got res=%h err=%b rv=%b busy=%b exp res=0 err=1 rv=1 busy=0",
                         RES, ERR, RES_VALID, BUSY);
    end
    tick();
    checks++;
    if ({ERR, RES_VALID} !== 2'b10) begin errors++; $display("FAIL tmo_after got err,rv=%b exp 10", {ERR, RES_VALID}); end
  endtask

  task automatic test_ce_stall();
    drive(1'b1, 4'd0, 2'b11, 8'd7, 8'd8, 1'b0);
    CE = 1'b0;
    tick();
    checks++;
    if ({RES, RES_VALID} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL ce_frozen got res=%h rv=%b exp res=0 rv=0", RES, RES_VALID);
    end
    CE = 1'b1;
    tick();
    checks++;
    if ({RES, RES_VALID} !== {16'd15, 1'b1}) begin
      errors++; $display("FAIL ce_resume got res=%0d rv=%b exp res=15 rv=1", RES, RES_VALID);
    end
    drive(1'b1, 4'd0, 2'b01, 8'd1, 8'd0, 1'b0);
    tick();
    INP_VALID = 2'b00;
    repeat (5) tick();
    CE = 1'b0;
    repeat (3) tick();
    checks++;
    if ({BUSY, RES_VALID, RES} !== {2'b10, 16'd15}) begin
      errors++; $display("FAIL ce_wait_hold got busy=%b rv=%b res=%0d exp busy=1 rv=0 res=15", BUSY, RES_VALID, RES);
    end
    CE = 1'b1;
    repeat (10) tick();
    checks++;
    if ({RES_VALID, BUSY} !== 2'b01) begin errors++; $display("FAIL ce_tmo_early got rv,busy=%b exp 01", {RES_VALID, BUSY}); end
    tick();
    checks++;
    if ({RES, ERR, RES_VALID} !== {16'h0000, 2'b11}) begin
      errors++; $display("FAIL ce_tmo_fire got res=%h err=%b rv=%b exp res=0 err=1 rv=1", RES, ERR, RES_VALID);
    end
  endtask

  task automatic test_rot_range();
    drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0);
    tick();
    checks++;
    if ({RES, ERR, RES_VALID} !== {16'h00C0, 2'b01}) begin
      errors++; $display("FAIL ror_ok got res=%h err=%b rv=%b exp res=00c0 err=0 rv=1", RES, ERR, RES_VALID);
    end
    drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h09, 1'b0);
    tick();
    checks++;
    if ({RES, ERR, RES_VALID} !== {16'h0000, 2'b11}) begin
      errors++; $display("FAIL ror_range got res=%h err=%b rv=%b exp res=0 err=1 rv=1", RES, ERR, RES_VALID);
    end
    INP_VALID = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    vec_t v [15];
    v[0]  = '{1'b0, 4'd0,  2'b11, 8'hF0, 8'h3C, 1'b0, 16'h0030, 6'b000000};
    v[1]  = '{1'b0, 4'd1,  2'b11, 8'hF0, 8'h3C, 1'b0, 16'h00CF, 6'b000000};
    v[2]  = '{1'b0, 4'd4,  2'b11, 8'hF0, 8'h3C, 1'b0, 16'h00CC, 6'b000000};
    v[3]  = '{1'b0, 4'd6,  2'b01, 8'hF0, 8'h55, 1'b0, 16'h000F, 6'b000000};
    v[4]  = '{1'b0, 4'd11, 2'b10, 8'h00, 8'h81, 1'b0, 16'h0002, 6'b000000};
    v[5]  = '{1'b1, 4'd2,  2'b11, 8'hFF, 8'h00, 1'b1, 16'h0100, 6'b100000};
    v[6]  = '{1'b1, 4'd7,  2'b10, 8'h12, 8'h00, 1'b0, 16'h00FF, 6'b010000};
    v[7]  = '{1'b0, 4'd14, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0000, 6'b000001};
    v[8]  = '{1'b1, 4'd3,  2'b11, 8'h0A, 8'h03, 1'b1, 16'h0006, 6'b000000};
    v[9]  = '{1'b1, 4'd6,  2'b10, 8'h00, 8'hFF, 1'b0, 16'h0100, 6'b100000};
    v[10] = '{1'b1, 4'd8,  2'b11, 8'h03, 8'h09, 1'b0, 16'h0000, 6'b000100};
    v[11] = '{1'b0, 4'd9,  2'b01, 8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000};
    v[12] = '{1'b1, 4'd11, 2'b11, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001};
    v[13] = '{1'b0, 4'd8,  2'b01, 8'h81, 8'h00, 1'b0, 16'h0040, 6'b000000};
    v[14] = '{1'b1, 4'd3,  2'b11, 8'h03, 8'h03, 1'b1, 16'h00FF, 6'b010000};
    for (int i = 0; i < 15; i++) begin
      drive(v[i].m, v[i].c, v[i].iv, v[i].a, v[i].b, v[i].ci);
      tick();
      checks++;
      if (RES_VALID !== 1'b1) begin errors++; $display("FAIL b2b[%0d] rv got %b exp 1", i, RES_VALID); end
      checks++;
      if (RES !== v[i].res) begin errors++; $display("FAIL b2b[%0d] res got %h exp %h", i, RES, v[i].res); end
      checks++;
      if ({COUT, OFLOW, G, L, E, ERR} !== v[i].fl) begin
        errors++; $display("FAIL b2b[%0d] flags got %b exp %b", i, {COUT, OFLOW, G, L, E, ERR}, v[i].fl);
      end
    end
    INP_VALID = 2'b00;
    tick();
    checks++;
    if (RES_VALID !== 1'b0) begin errors++; $display("FAIL b2b_end rv got %b exp 0", RES_VALID); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd1, 1'b0);
    tick();
    drive(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
    tick();
    checks++;
    if ({RES, BUSY} !== {16'd2, 1'b1}) begin
      errors++; $display("FAIL rstmul_pre got res=%0d busy=%b exp res=2 busy=1", RES, BUSY);
    end
    INP_VALID = 2'b00;
    RST = 1'b0;
    #1;
    checks++;
    if ({RES, COUT, OFLOW, G, L, E, ERR, RES_VALID, BUSY} !== 24'h0) begin
      errors++; $display("FAIL rstmul_clear got %h exp 0", {RES, COUT, OFLOW, G, L, E, ERR, RES_VALID, BUSY});
    end
    tick();
    RST = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (RES_VALID !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmul_late got %0d active cycles exp 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_rotate_wait();
    test_timeout();
    test_ce_stall();
    test_rot_range();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
